// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin share of one AR+R read channel between two burst requesters
//   clk, rst_n                   clock, synchronous active-low reset
//   m0_*/m1_* ar{addr,valid,burst} in, arready/rvalid/rlast out   requester ports
//   m_rdata                      read data broadcast to both requesters
//   araddr/arvalid/arburst out, arready/rdata/rvalid/rlast in      memory port
//   grant, busy, proto_err       owner, state != IDLE, sticky protocol error
module axi_rd_arbiter #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int LENW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   m0_araddr,
    input  logic            m0_arvalid,
    input  logic [LENW-1:0] m0_arburst,
    output logic            m0_arready,
    output logic            m0_rvalid,
    output logic            m0_rlast,
    input  logic [AW-1:0]   m1_araddr,
    input  logic            m1_arvalid,
    input  logic [LENW-1:0] m1_arburst,
    output logic            m1_arready,
    output logic            m1_rvalid,
    output logic            m1_rlast,
    output logic [DW-1:0]   m_rdata,
    output logic [AW-1:0]   araddr,
    output logic            arvalid,
    output logic [LENW-1:0] arburst,
    input  logic            arready,
    input  logic [DW-1:0]   rdata,
    input  logic            rvalid,
    input  logic            rlast,
    output logic            grant,
    output logic            busy,
    output logic            proto_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t          r_state;
    logic            r_grant;
    logic            r_last_grant;
    logic            r_proto_err;
    logic [LENW:0]   r_beat_cnt;
    logic [LENW-1:0] r_len;
    logic            w_addr;
    logic            w_data;
    logic            w_last_due;
    assign w_addr     = r_state == ADDR;
    assign w_data     = r_state == DATA;
    assign w_last_due = r_beat_cnt == {1'b0, r_len};
    assign arvalid    = w_addr & (r_grant ? m1_arvalid : m0_arvalid);
    assign araddr     = w_addr ? (r_grant ? m1_araddr : m0_araddr) : '0;
    assign arburst    = w_addr ? (r_grant ? m1_arburst : m0_arburst) : '0;
    assign m0_arready = w_addr & ~r_grant & arready;
    assign m1_arready = w_addr & r_grant & arready;
    assign m0_rvalid  = w_data & ~r_grant & rvalid;
    assign m1_rvalid  = w_data & r_grant & rvalid;
    assign m0_rlast   = w_data & ~r_grant & rlast;
    assign m1_rlast   = w_data & r_grant & rlast;
    assign m_rdata    = w_data ? rdata : '0;
    assign grant      = r_grant;
    assign busy       = r_state != IDLE;
    assign proto_err  = r_proto_err;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_proto_err  <= 1'b0;
            r_beat_cnt   <= '0;
            r_len        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_arvalid | m1_arvalid) begin
                        // a tie goes to whoever did not own the previous burst
                        r_grant <= (m0_arvalid & m1_arvalid) ? ~r_last_grant : m1_arvalid;
                        r_state <= ADDR;
                    end
                    if (rvalid) r_proto_err <= 1'b1;
                end
                ADDR: begin
                    if (arvalid & arready) begin
                        r_len        <= arburst;
                        r_last_grant <= r_grant;
                        r_beat_cnt   <= '0;
                        r_state      <= DATA;
                    end
                    if (rvalid) r_proto_err <= 1'b1;
                end
                DATA: begin
                    if (rvalid) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (rlast) begin
                            r_state <= IDLE;
                            if (!w_last_due) r_proto_err <= 1'b1;
                        end else if (w_last_due) begin
                            // memory overran the burst; keep waiting for its rlast
                            r_proto_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed and randomized bursts checked against a round-robin reference model
module tb_axi_rd_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_araddr, m1_araddr, araddr, rdata, m_rdata;
    logic [3:0]  m0_arburst, m1_arburst, arburst;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic        m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic        arvalid, arready, rvalid, rlast, grant, busy, proto_err;
    int          vectors = 0;
    int          miscompares = 0;
    int          prev_win = 1;
    bit          exp_perr = 1'b0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.DW(32), .AW(32), .LENW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arburst(m0_arburst),
        .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arburst(m1_arburst),
        .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
        .m_rdata(m_rdata), .araddr(araddr), .arvalid(arvalid), .arburst(arburst),
        .arready(arready), .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
        .grant(grant), .busy(busy), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_arvalid"}, 32'(arvalid), 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_arburst"}, 32'(arburst), 0);
        chk({tag, "_arready"}, 32'({m1_arready, m0_arready}), 0);
        chk({tag, "_rvalid"}, 32'({m1_rvalid, m0_rvalid}), 0);
        chk({tag, "_rlast"}, 32'({m1_rlast, m0_rlast}), 0);
        chk({tag, "_perr"}, 32'(proto_err), 0);
    endtask

    task automatic clear_inputs;
        m0_arvalid = 0; m1_arvalid = 0; m0_araddr = 0; m1_araddr = 0;
        m0_arburst = 0; m1_arburst = 0; arready = 0; rvalid = 0; rlast = 0; rdata = 0;
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        chk_reset_outputs(tag);
        rst_n = 1;
        prev_win = 1;
        exp_perr = 0;
    endtask

    // One arbitrated burst from IDLE; nbeats < 0 means the memory returns the correct count.
    task automatic run_burst(input string tag, input bit keep, input int ar_dly, input int nbeats);
        int          win, n;
        logic [31:0] a;
        logic [3:0]  l;
        win = (m0_arvalid && m1_arvalid) ? 1 - prev_win : (m1_arvalid ? 1 : 0);
        a = win ? m1_araddr : m0_araddr;
        l = win ? m1_arburst : m0_arburst;
        n = nbeats < 0 ? int'(l) + 1 : nbeats;
        tick();
        chk({tag, "_busy_addr"}, 32'(busy), 1);
        chk({tag, "_grant"}, 32'(grant), win);
        chk({tag, "_arburst"}, 32'(arburst), 32'(l));
        for (int d = 0; d < ar_dly; d++) begin
            chk({tag, "_arvalid_wait"}, 32'(arvalid), 1);
            chk({tag, "_araddr_wait"}, araddr, a);
            chk({tag, "_arready_wait"}, 32'({m1_arready, m0_arready}), 0);
            tick();
        end
        arready = 1;
        #1;
        chk({tag, "_arvalid"}, 32'(arvalid), 1);
        chk({tag, "_araddr"}, araddr, a);
        chk({tag, "_arready_route"}, 32'({m1_arready, m0_arready}), win ? 2 : 1);
        tick();
        arready = 0;
        if (!keep) begin
            if (win == 1) m1_arvalid = 0; else m0_arvalid = 0;
        end
        prev_win = win;
        for (int i = 0; i < n; i++) begin
            rvalid = 1;
            rdata = $urandom;
            rlast = (i == n - 1);
            #1;
            chk({tag, "_rvalid"}, 32'({m1_rvalid, m0_rvalid}), win ? 2 : 1);
            chk({tag, "_rlast"}, 32'({m1_rlast, m0_rlast}), rlast ? (win ? 2 : 1) : 0);
            chk({tag, "_rdata"}, m_rdata, rdata);
            tick();
        end
        rvalid = 0;
        rlast = 0;
        if (n != int'(l) + 1) exp_perr = 1;
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_arvalid_end"}, 32'(arvalid), 0);
        chk({tag, "_perr"}, 32'(proto_err), 32'(exp_perr));
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        do_reset("reset");

        // m0 alone, 9-beat burst, arready immediately
        m0_arvalid = 1; m0_araddr = 32'h1000; m0_arburst = 8;
        run_burst("m0_solo", 0, 0, -1);

        // simultaneous first requests after reset: m0 first, then m1
        do_reset("reset2");
        m0_arvalid = 1; m0_araddr = 32'h2000; m0_arburst = 2;
        m1_arvalid = 1; m1_araddr = 32'h3000; m1_arburst = 1;
        run_burst("tie_first", 0, 0, -1);
        run_burst("tie_second", 0, 0, -1);

        // both requesting continuously: grants alternate
        m0_arvalid = 1; m0_araddr = 32'h4000; m0_arburst = 3;
        m1_arvalid = 1; m1_araddr = 32'h5000; m1_arburst = 2;
        for (int b = 0; b < 4; b++) run_burst("rr", 1, 0, -1);
        m0_arvalid = 0; m1_arvalid = 0;

        // memory stalls arready for 5 cycles on an m1 burst
        m1_arvalid = 1; m1_araddr = 32'hCAFE_0040; m1_arburst = 4;
        run_burst("ar_stall", 0, 5, -1);

        // requester withdraws in ADDR: arvalid follows, no re-arbitration
        m0_arvalid = 1; m0_araddr = 32'h6000; m0_arburst = 0;
        tick();
        m0_arvalid = 0;
        m1_arvalid = 1;
        #1;
        chk("withdraw_arvalid", 32'(arvalid), 0);
        chk("withdraw_busy", 32'(busy), 1);
        chk("withdraw_grant", 32'(grant), 0);
        tick();
        chk("withdraw_hold", 32'(grant), 0);
        m1_arvalid = 0;
        m0_arvalid = 1;
        prev_win = 1;
        run_burst("withdraw_resume", 0, 0, -1);
        chk("withdraw_grant_end", 32'(grant), 0);

        // early rlast: arburst=3 but only 2 beats
        m1_arvalid = 1; m1_araddr = 32'h7000; m1_arburst = 3;
        run_burst("short_burst", 0, 0, 2);

        // overlong burst: error at the expected last beat, FSM waits for rlast
        do_reset("reset3");
        m0_arvalid = 1; m0_araddr = 32'h7100; m0_arburst = 1;
        run_burst("long_burst", 0, 0, 4);

        // stray beat while idle
        do_reset("reset4");
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        #1;
        chk("stray_rvalid", 32'({m1_rvalid, m0_rvalid}), 0);
        tick();
        rvalid = 0;
        chk("stray_perr", 32'(proto_err), 1);
        chk("stray_busy", 32'(busy), 0);

        // reset during beat 4 of 16, then a beat still in flight
        do_reset("reset5");
        m0_arvalid = 1; m0_araddr = 32'h8000; m0_arburst = 15;
        tick();
        arready = 1;
        tick();
        arready = 0; m0_arvalid = 0;
        for (int i = 0; i < 3; i++) begin
            rvalid = 1; rdata = $urandom;
            tick();
        end
        rst_n = 0;
        tick();
        chk_reset_outputs("midrst");
        rst_n = 1;
        #1;
        chk("midrst_stray_rvalid", 32'({m1_rvalid, m0_rvalid}), 0);
        tick();
        rvalid = 0;
        chk("midrst_perr", 32'(proto_err), 1);

        // randomized traffic against the round-robin model
        do_reset("reset6");
        for (int it = 0; it < 30; it++) begin
            m0_arvalid = 1'($urandom_range(0, 1));
            m1_arvalid = 1'($urandom_range(0, 1));
            if (!m0_arvalid && !m1_arvalid) m1_arvalid = 1;
            m0_araddr = $urandom; m1_araddr = $urandom;
            m0_arburst = 4'($urandom_range(0, 15));
            m1_arburst = 4'($urandom_range(0, 15));
            run_burst("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1);
        end
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
